// File: rtl/io_datamem_pkg.sv
// rtl/io_datamem_pkg.sv - shared constants and helpers for io_datamem
// Holds the IO slot map constants and the byte-lane merge function.
package io_datamem_pkg;

  // IO slot map (slot = addr[6:2] when addr[IO_SEL_BIT] is set)
  localparam int IN_BASE     = 0;
  localparam int OUT_BASE    = 8;
  localparam int STATUS_SLOT = 31;
  localparam int IO_SEL_BIT  = 7;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - per-channel switch synchroniser, debouncer and change detector
// Optional feature macro: IO_DEBOUNCE_EN (debounce counter present when defined).
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   pin          : raw asynchronous switch bits
//   deb          : accepted (debounced) value
//   change       : high in the cycle before the edge at which deb takes a new value
module io_debounce #(
  parameter int IN_W            = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] pin,
  output logic [IN_W-1:0] deb,
  output logic            change
);

  logic [IN_W-1:0] sync1;
  logic [IN_W-1:0] sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]   cnt;
  logic [IN_W-1:0] deb_q;

  // Asserted exactly when the coming edge loads deb_q, so the parent's
  // flag rises on the same edge as the debounced value.
  assign change = (sync2 != deb_q) && (cnt == CNT_LAST);
  assign deb    = deb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      deb_q <= '0;
    end else if (sync2 == deb_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb_q <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // sync2 is the accepted value; it is about to change whenever sync1 differs.
  assign deb    = sync2;
  assign change = (sync1 != sync2);
`endif

endmodule

// File: rtl/io_datamem.sv
// rtl/io_datamem.sv - MEM-stage data RAM plus memory-mapped switch inputs and display outputs
// Optional feature macro: IO_DEBOUNCE_EN (input debounce counters).
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   addr, wdata  : byte address (addr[7:2] decoded) and write data
//   be, we, re   : byte-lane enables, write strobe, read strobe
//   rdata        : registered read data, held until the next re
//   sw_in        : raw switch pins, channel k at [k*IN_W +: IN_W]
//   disp_out     : output register j low bits at [j*OUT_W +: OUT_W]
//   in_event     : OR of the sticky input change flags
module io_datamem
  import io_datamem_pkg::*;
#(
  parameter int RAM_AW          = 5,
  parameter int NUM_IN          = 2,
  parameter int IN_W            = 5,
  parameter int NUM_OUT         = 3,
  parameter int OUT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  input  logic                     we,
  input  logic                     re,
  output logic [31:0]              rdata,
  input  logic [NUM_IN*IN_W-1:0]   sw_in,
  output logic [NUM_OUT*OUT_W-1:0] disp_out,
  output logic                     in_event
);

  logic              io_sel;
  logic [4:0]        slot;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              unused_addr;

  assign io_sel      = addr[IO_SEL_BIT];
  assign slot        = addr[6:2];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign wr_en       = we && (be != 4'b0000);
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  logic [31:0]     ram     [0:(2**RAM_AW)-1];
  logic [31:0]     out_reg [NUM_OUT];
  logic [IN_W-1:0] deb_val [NUM_IN];
  logic [NUM_IN-1:0] chg;
  logic [NUM_IN-1:0] flags;
  logic [NUM_IN-1:0] clr;
  logic [31:0]     rd_word;

  genvar k, j;
  generate
    for (k = 0; k < NUM_IN; k++) begin : g_in
      io_debounce #(
        .IN_W           (IN_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clock (clock),
        .reset (reset),
        .pin   (sw_in[k*IN_W +: IN_W]),
        .deb   (deb_val[k]),
        .change(chg[k])
      );
      // W1C respects byte lanes: a status bit clears only if its lane is enabled.
      assign clr[k] = wr_en && io_sel && (slot == 5'(STATUS_SLOT))
                      && be[k/8] && wdata[k];
    end
    for (j = 0; j < NUM_OUT; j++) begin : g_out
      assign disp_out[j*OUT_W +: OUT_W] = out_reg[j][OUT_W-1:0];
    end
  endgenerate

  assign in_event = |flags;

  // RAM contents survive reset, so it lives in its own unreset process.
  always_ff @(posedge clock) begin
    if (wr_en && !io_sel) ram[ram_idx] <= byte_merge(ram[ram_idx], wdata, be);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
      flags <= '0;
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_en && io_sel && (slot == 5'(OUT_BASE + i)))
          out_reg[i] <= byte_merge(out_reg[i], wdata, be);
      end
      // A new change on the same edge as its W1C keeps the flag set.
      flags <= (flags & ~clr) | chg;
      // rd_word is built from pre-edge state, giving read-before-write.
      if (re) rdata <= rd_word;
    end
  end

  always_comb begin
    rd_word = '0;
    if (!io_sel) begin
      rd_word = ram[ram_idx];
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (slot == 5'(IN_BASE + i)) rd_word[IN_W-1:0] = deb_val[i];
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (slot == 5'(OUT_BASE + i)) rd_word = out_reg[i];
      end
      if (slot == 5'(STATUS_SLOT)) rd_word[NUM_IN-1:0] = flags;
    end
  end

endmodule

// File: tb/tb_io_datamem.sv
// tb/tb_io_datamem.sv - scoreboard bench for io_datamem
module tb_io_datamem;

  localparam int RAM_AW  = 5;
  localparam int NUM_IN  = 2;
  localparam int IN_W    = 5;
  localparam int NUM_OUT = 3;
  localparam int OUT_W   = 8;
  localparam int DC      = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int          LAT         = DC + 2;
  localparam logic [31:0] GLITCH_FLAG = 32'h0;
`else
  localparam int          LAT         = 2;
  localparam logic [31:0] GLITCH_FLAG = 32'h1;
`endif

  logic                     mem_clk = 1'b0;
  logic                     reset;
  logic [31:0]              addr, wdata, rdata;
  logic [3:0]               be;
  logic                     we, re;
  logic [NUM_IN*IN_W-1:0]   sw_in;
  logic [NUM_OUT*OUT_W-1:0] disp_out;
  logic                     in_event;

  io_datamem #(
    .RAM_AW(RAM_AW), .NUM_IN(NUM_IN), .IN_W(IN_W),
    .NUM_OUT(NUM_OUT), .OUT_W(OUT_W), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock(mem_clk), .reset(reset), .addr(addr), .wdata(wdata), .be(be),
    .we(we), .re(re), .rdata(rdata), .sw_in(sw_in), .disp_out(disp_out),
    .in_event(in_event)
  );

  always #5 mem_clk = ~mem_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        re_q;

  always @(posedge mem_clk or posedge reset) begin
    if (reset) re_q <= 1'b0;
    else       re_q <= re;
  end

  always @(negedge mem_clk) begin
    logic [31:0] e;
    string nm;
    if (re_q) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: got %08h, no expected value queued", rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rdata !== e) begin
          n_bad++;
          $display("FAIL %s: got %08h expected %08h", nm, rdata, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, e);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] b,
                    input logic [31:0] e, input string nm);
    @(negedge mem_clk);
    we = w; re = r; addr = a; wdata = d; be = b;
    if (r) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge mem_clk);
  endtask

  task automatic idle_n(input int n);
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0;
    repeat (n) @(posedge mem_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; be = '0; sw_in = '0;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    reset = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_disp", 32'(disp_out), 32'h0);
    check("reset_event", 32'(in_event), 32'h0);

    // RAM with byte enables
    op(1, 0, 32'h04, 32'hDEADBEEF, 4'hF, 0, "");
    op(1, 0, 32'h04, 32'h000000AA, 4'h1, 0, "");
    op(0, 1, 32'h04, 0, 4'h0, 32'hDEADBEAA, "ram_be");
    op(1, 0, 32'h04, 32'h12345678, 4'h0, 0, "");
    op(0, 1, 32'h04, 0, 4'h0, 32'hDEADBEAA, "ram_be0");
    op(1, 0, 32'h7C, 32'hCAFEF00D, 4'hF, 0, "");
    op(0, 1, 32'h7C, 0, 4'h0, 32'hCAFEF00D, "ram_top");

    // Same-cycle read/write on output slot 8
    op(1, 1, 32'hA0, 32'h11, 4'hF, 32'h0, "hazard_old");
    #1 check("hazard_disp", 32'(disp_out[7:0]), 32'h11);
    op(0, 1, 32'hA0, 0, 4'h0, 32'h11, "hazard_new");
    op(1, 0, 32'hA8, 32'h12345699, 4'hF, 0, "");
    op(0, 1, 32'hA8, 0, 4'h0, 32'h12345699, "out2_full");
    #1 check("disp_all", 32'(disp_out), 32'h00990011);

    // Unmapped slot and read-only input slot
    op(1, 0, 32'h94, 32'hFFFFFFFF, 4'hF, 0, "");
    op(1, 0, 32'h84, 32'hFFFFFFFF, 4'hF, 0, "");
    op(0, 1, 32'h94, 0, 4'h0, 32'h0, "unmapped_rd");
    op(0, 1, 32'h84, 0, 4'h0, 32'h0, "input_ro");
    #1 check("disp_unchanged", 32'(disp_out), 32'h00990011);

    // Short glitch on channel 0
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0; sw_in[4:0] = 5'h15;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    sw_in[4:0] = 5'h00;
    repeat (LAT + 3) @(posedge mem_clk);
    op(0, 1, 32'h80, 0, 4'h0, 32'h0, "glitch_in0");
    op(0, 1, 32'hFC, 0, 4'h0, GLITCH_FLAG, "glitch_status");
    op(1, 0, 32'hFC, 32'h1, 4'hF, 0, "");
    op(0, 1, 32'hFC, 0, 4'h0, 32'h0, "status_clr0");

    // Held change on channel 0: in_event rises exactly at the accept edge
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0; sw_in[4:0] = 5'h15;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge mem_clk);
      #1;
      if (i == LAT - 1) check("event_early", 32'(in_event), 32'h0);
      if (i == LAT)     check("event_edge", 32'(in_event), 32'h1);
    end
    op(0, 1, 32'h80, 0, 4'h0, 32'h15, "held_in0");
    op(0, 1, 32'hFC, 0, 4'h0, 32'h1, "held_status");

    // W1C, then clear racing a new channel-1 change
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0; sw_in[9:5] = 5'h0A;
    repeat (LAT + 2) @(posedge mem_clk);
    op(0, 1, 32'hFC, 0, 4'h0, 32'h3, "status_both");
    op(1, 0, 32'hFC, 32'h1, 4'hF, 0, "");
    op(0, 1, 32'hFC, 0, 4'h0, 32'h2, "w1c_bit0");
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0; sw_in[9:5] = 5'h00;
    repeat (LAT - 1) @(posedge mem_clk);
    op(1, 0, 32'hFC, 32'h2, 4'hF, 0, "");
    op(0, 1, 32'hFC, 0, 4'h0, 32'h2, "set_wins");
    op(0, 1, 32'h84, 0, 4'h0, 32'h0, "in1_back");
    #1 check("event_held", 32'(in_event), 32'h1);

    // Asynchronous reset mid-debounce with nonzero state
    op(0, 1, 32'h04, 0, 4'h0, 32'hDEADBEAA, "pre_rst_rd");
    @(negedge mem_clk);
    we = 1'b0; re = 1'b0; sw_in[9:5] = 5'h1F;
    repeat (3) @(posedge mem_clk);
    #3;
    reset = 1'b1;
    sw_in = '0;
    #1;
    check("rst_disp", 32'(disp_out), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_event", 32'(in_event), 32'h0);
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk);
    reset = 1'b0;
    op(0, 1, 32'hFC, 0, 4'h0, 32'h0, "rst_status");
    op(0, 1, 32'h04, 0, 4'h0, 32'hDEADBEAA, "ram_keep0");
    op(0, 1, 32'h7C, 0, 4'h0, 32'hCAFEF00D, "ram_keep1");
    op(0, 1, 32'hA0, 0, 4'h0, 32'h0, "rst_out0");
    idle_n(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
